// File: rtl/spi_reg_responder_if.sv
// spi_reg_responder_if: SPI pins plus the local register port of the SPI register responder
interface spi_reg_responder_if #(parameter int ADDR_W = 4);
  logic SCK, SS, MOSI, MISO, MISO_OE;
  logic [ADDR_W-1:0] LOC_ADDR;
  logic [7:0] LOC_WDATA, LOC_RDATA;
  logic LOC_WE, WR_PULSE, FRAME_ERR, ERR_CLR, BUSY;
  logic [6:0] WR_ADDR;
  modport slave (
    input SCK, SS, MOSI, LOC_ADDR, LOC_WDATA, LOC_WE, ERR_CLR,
    output MISO, MISO_OE, LOC_RDATA, WR_PULSE, WR_ADDR, FRAME_ERR, BUSY
  );
  modport master (
    output SCK, SS, MOSI, LOC_ADDR, LOC_WDATA, LOC_WE, ERR_CLR,
    input MISO, MISO_OE, LOC_RDATA, WR_PULSE, WR_ADDR, FRAME_ERR, BUSY
  );
endinterface

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: mode-0 SPI target exposing a byte register file, shared with a local PCLK-side port
module spi_reg_responder #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic PCLK,
  input logic PRESETn,
  spi_reg_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
  logic sck_d, ss_d, rw;
  logic [2:0] bit_cnt;
  logic [6:0] shreg, addr, addr_nx;
  logic [7:0] tx_shift, sh_nx;
  logic [7:0] regs [DEPTH];
  logic sck_rise, sck_fall, ss_rise, ss_fall;
  function automatic logic in_range(input logic [6:0] a);
    return int'(a) < DEPTH;
  endfunction
  function automatic logic [7:0] rd(input logic [6:0] a);
    return in_range(a) ? regs[a[ADDR_W-1:0]] : 8'h00;
  endfunction
  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_d;
  assign ss_rise = ss_q[SYNC_STAGES-1] & ~ss_d;
  assign ss_fall = ~ss_q[SYNC_STAGES-1] & ss_d;
  assign sh_nx = {shreg, mosi_q[SYNC_STAGES-1]};
  assign addr_nx = in_range(addr) ? 7'((addr + 7'd1) & 7'(DEPTH - 1)) : addr + 7'd1;
  assign bus.MISO_OE = state == DATA && rw;
  assign bus.BUSY = state != IDLE;
  // SS sync resets low so a select already asserted at reset release is not seen as a new frame
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sck_q <= '0;
      ss_q <= '0;
      mosi_q <= '0;
      sck_d <= 1'b0;
      ss_d <= 1'b0;
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      tx_shift <= '0;
      rw <= 1'b0;
      addr <= '0;
      bus.MISO <= 1'b0;
      bus.LOC_RDATA <= '0;
      bus.WR_PULSE <= 1'b0;
      bus.WR_ADDR <= '0;
      bus.FRAME_ERR <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], bus.SCK};
      ss_q <= {ss_q[SYNC_STAGES-2:0], bus.SS};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.MOSI};
      sck_d <= sck_q[SYNC_STAGES-1];
      ss_d <= ss_q[SYNC_STAGES-1];
      bus.WR_PULSE <= 1'b0;
      bus.LOC_RDATA <= regs[bus.LOC_ADDR];
      if (bus.ERR_CLR) bus.FRAME_ERR <= 1'b0;
      // local write first so a same-cycle SPI write to the same register overrides it
      if (bus.LOC_WE) regs[bus.LOC_ADDR] <= bus.LOC_WDATA;
      if (ss_rise) begin
        state <= IDLE;
        bit_cnt <= '0;
        if (bit_cnt != 3'd0) bus.FRAME_ERR <= 1'b1;
      end else begin
        case (state)
          IDLE: if (ss_fall) begin
            state <= CMD;
            bit_cnt <= '0;
            shreg <= '0;
          end
          CMD: if (sck_rise) begin
            shreg <= sh_nx[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw <= sh_nx[7];
              addr <= sh_nx[6:0];
              tx_shift <= rd(sh_nx[6:0]);
              state <= DATA;
            end
          end
          DATA: begin
            if (sck_fall && rw) begin
              bus.MISO <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (sck_rise) begin
              shreg <= sh_nx[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!rw && in_range(addr)) begin
                  regs[addr[ADDR_W-1:0]] <= sh_nx;
                  bus.WR_PULSE <= 1'b1;
                  bus.WR_ADDR <= addr;
                end
                if (rw) tx_shift <= rd(addr_nx);
                addr <= addr_nx;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_responder.sv
// tb_spi_reg_responder: table vectors, corner-case sequences and random frames against a register-file model
module tb_spi_reg_responder;
  localparam int HALF = 6;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  spi_reg_responder_if #(.ADDR_W(4)) bus();
  spi_reg_responder #(.DEPTH(16), .ADDR_W(4), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );
  always #5 PCLK = ~PCLK;
  typedef struct {
    logic [7:0] cmd;
    logic [2:0][7:0] d;
    int nd;
    logic [2:0][7:0] er;
    int np;
    int ca;
    logic [7:0] cv;
  } vec_t;
  vec_t tv[7];
  int nchk = 0;
  int nerr = 0;
  logic [7:0] m [16];
  int wq[$];
  int ewq[$];
  logic oe_cmd, oe_dat;
  always @(negedge PCLK) if (bus.WR_PULSE) wq.push_back(int'(bus.WR_ADDR));
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(logic [7:0] c, logic [23:0] dd, int nd, logic [23:0] ee, int np, int ca, logic [7:0] cv);
    vec_t v;
    v.cmd = c; v.d = dd; v.nd = nd; v.er = ee; v.np = np; v.ca = ca; v.cv = cv;
    return v;
  endfunction
  // reference: whole-frame effect on the register file from the addressing rules
  function automatic void model_frame(input logic [7:0] c, input logic [2:0][7:0] d, input int nd, output logic [2:0][7:0] er);
    int a;
    a = int'(c[6:0]);
    er = '0;
    for (int k = 0; k < nd; k++) begin
      if (c[7]) er[k] = a < 16 ? m[a] : 8'h00;
      else if (a < 16) begin
        m[a] = d[k];
        ewq.push_back(a);
      end
      a = a < 16 ? (a + 1) % 16 : (a + 1) % 128;
    end
  endfunction
  task automatic xfer_bit(input logic b, input bit coll, output logic r, output logic oe);
    bus.MOSI = b;
    repeat (HALF) @(negedge PCLK);
    bus.SCK = 1'b1;
    r = bus.MISO;
    oe = bus.MISO_OE;
    if (coll) begin
      repeat (2) @(negedge PCLK);
      bus.LOC_WE = 1'b1;
      @(negedge PCLK);
      bus.LOC_WE = 1'b0;
      repeat (HALF - 3) @(negedge PCLK);
    end else repeat (HALF) @(negedge PCLK);
    bus.SCK = 1'b0;
  endtask
  task automatic frame(input logic [7:0] c, input logic [2:0][7:0] d, input int nd, output logic [2:0][7:0] rx);
    logic r, oe;
    rx = '0;
    bus.SS = 1'b0;
    repeat (2 * HALF) @(negedge PCLK);
    oe_cmd = 1'b0;
    oe_dat = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(c[i], 1'b0, r, oe);
      oe_cmd |= oe;
    end
    for (int k = 0; k < nd; k++)
      for (int i = 7; i >= 0; i--) begin
        xfer_bit(d[k][i], 1'b0, r, oe);
        rx[k][i] = r;
        oe_dat &= oe;
      end
    repeat (HALF) @(negedge PCLK);
    bus.SS = 1'b1;
    repeat (12) @(negedge PCLK);
  endtask
  task automatic cmp_wq(input string nm);
    chk({nm, "_wr_count"}, wq.size(), ewq.size());
    for (int i = 0; i < wq.size() && i < ewq.size(); i++) chk($sformatf("%s_wr_addr%0d", nm, i), wq[i], ewq[i]);
    wq.delete();
    ewq.delete();
  endtask
  task automatic loc_read(input int a, output logic [7:0] v);
    bus.LOC_ADDR = 4'(a);
    @(negedge PCLK);
    v = bus.LOC_RDATA;
  endtask
  task automatic loc_write(input int a, input logic [7:0] v);
    bus.LOC_ADDR = 4'(a);
    bus.LOC_WDATA = v;
    bus.LOC_WE = 1'b1;
    @(negedge PCLK);
    bus.LOC_WE = 1'b0;
    m[a] = v;
  endtask
  initial begin
    logic [2:0][7:0] er, rx;
    logic [7:0] b, c;
    logic r, oe;
    int nd;
    logic [2:0][7:0] d;
    bus.SCK = 1'b0; bus.SS = 1'b1; bus.MOSI = 1'b0; bus.ERR_CLR = 1'b0;
    bus.LOC_ADDR = '0; bus.LOC_WDATA = '0; bus.LOC_WE = 1'b0;
    foreach (m[i]) m[i] = 8'h00;
    repeat (3) @(negedge PCLK);
    chk("rst_miso", bus.MISO, 0);
    chk("rst_miso_oe", bus.MISO_OE, 0);
    chk("rst_loc_rdata", bus.LOC_RDATA, 0);
    chk("rst_wr_pulse", bus.WR_PULSE, 0);
    chk("rst_wr_addr", bus.WR_ADDR, 0);
    chk("rst_frame_err", bus.FRAME_ERR, 0);
    chk("rst_busy", bus.BUSY, 0);
    PRESETn = 1'b1;
    repeat (10) @(negedge PCLK);
    tv[0] = mk(8'h03, 24'h0000A5, 1, 24'h000000, 1, 3, 8'hA5);
    tv[1] = mk(8'h83, 24'h000000, 1, 24'h0000A5, 0, 3, 8'hA5);
    tv[2] = mk(8'h0E, 24'h332211, 3, 24'h000000, 3, 0, 8'h33);
    tv[3] = mk(8'h8E, 24'h000000, 3, 24'h332211, 0, 15, 8'h22);
    tv[4] = mk(8'h20, 24'h0000FF, 1, 24'h000000, 0, 0, 8'h33);
    tv[5] = mk(8'hA0, 24'h000000, 1, 24'h000000, 0, 14, 8'h11);
    tv[6] = mk(8'h8F, 24'h000000, 2, 24'h003322, 0, 3, 8'hA5);
    for (int v = 0; v < 7; v++) begin
      model_frame(tv[v].cmd, tv[v].d, tv[v].nd, er);
      frame(tv[v].cmd, tv[v].d, tv[v].nd, rx);
      if (tv[v].cmd[7])
        for (int k = 0; k < tv[v].nd; k++) chk($sformatf("vec%0d_rx%0d", v, k), rx[k], tv[v].er[k]);
      chk($sformatf("vec%0d_pulses", v), wq.size(), tv[v].np);
      cmp_wq($sformatf("vec%0d", v));
      loc_read(tv[v].ca, b);
      chk($sformatf("vec%0d_reg%0d", v, tv[v].ca), b, tv[v].cv);
      chk($sformatf("vec%0d_frame_err", v), bus.FRAME_ERR, 0);
      chk($sformatf("vec%0d_busy", v), bus.BUSY, 0);
    end
    loc_write(5, 8'h3C);
    model_frame(8'h85, 24'h0, 1, er);
    frame(8'h85, 24'h0, 1, rx);
    chk("read5_rx", rx[0], 8'h3C);
    chk("read5_oe_cmd", oe_cmd, 0);
    chk("read5_oe_data", oe_dat, 1);
    chk("read5_oe_after", bus.MISO_OE, 0);
    bus.SS = 1'b0;
    repeat (2 * HALF) @(negedge PCLK);
    for (int i = 7; i >= 0; i--) xfer_bit(c[0] & 1'b0 | (i == 1), 1'b0, r, oe);
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, 1'b0, r, oe);
    repeat (HALF) @(negedge PCLK);
    bus.SS = 1'b1;
    repeat (12) @(negedge PCLK);
    chk("abort_frame_err", bus.FRAME_ERR, 1);
    chk("abort_busy", bus.BUSY, 0);
    cmp_wq("abort");
    loc_read(2, b);
    chk("abort_reg2", b, m[2]);
    bus.ERR_CLR = 1'b1;
    @(negedge PCLK);
    bus.ERR_CLR = 1'b0;
    @(negedge PCLK);
    chk("err_clr", bus.FRAME_ERR, 0);
    model_frame(8'h02, 24'h00005A, 1, er);
    frame(8'h02, 24'h00005A, 1, rx);
    cmp_wq("after_abort");
    loc_read(2, b);
    chk("after_abort_reg2", b, 8'h5A);
    chk("after_abort_frame_err", bus.FRAME_ERR, 0);
    bus.LOC_ADDR = 4'd1;
    bus.LOC_WDATA = 8'h99;
    c = 8'h01;
    b = 8'h77;
    bus.SS = 1'b0;
    repeat (2 * HALF) @(negedge PCLK);
    for (int i = 7; i >= 0; i--) xfer_bit(c[i], 1'b0, r, oe);
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], i == 0, r, oe);
    repeat (HALF) @(negedge PCLK);
    bus.SS = 1'b1;
    repeat (12) @(negedge PCLK);
    m[1] = 8'h77;
    ewq.push_back(1);
    cmp_wq("collision");
    loc_read(1, b);
    chk("collision_reg1", b, 8'h77);
    bus.SS = 1'b0;
    repeat (2 * HALF) @(negedge PCLK);
    for (int i = 0; i < 3; i++) xfer_bit(1'b1, 1'b0, r, oe);
    PRESETn = 1'b0;
    #1;
    chk("midrst_busy", bus.BUSY, 0);
    chk("midrst_miso_oe", bus.MISO_OE, 0);
    chk("midrst_miso", bus.MISO, 0);
    chk("midrst_wr_addr", bus.WR_ADDR, 0);
    chk("midrst_wr_pulse", bus.WR_PULSE, 0);
    chk("midrst_frame_err", bus.FRAME_ERR, 0);
    chk("midrst_loc_rdata", bus.LOC_RDATA, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    foreach (m[i]) m[i] = 8'h00;
    repeat (20) @(negedge PCLK);
    chk("midrst_stays_idle", bus.BUSY, 0);
    loc_read(1, b);
    chk("midrst_reg1", b, 8'h00);
    bus.SS = 1'b1;
    repeat (12) @(negedge PCLK);
    wq.delete();
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) loc_write($urandom_range(0, 15), 8'($urandom));
      c = {1'($urandom), 7'($urandom_range(0, 31))};
      nd = $urandom_range(1, 3);
      d = 24'($urandom);
      model_frame(c, d, nd, er);
      frame(c, d, nd, rx);
      if (c[7])
        for (int k = 0; k < nd; k++) chk($sformatf("rand%0d_rx%0d", t, k), rx[k], er[k]);
      cmp_wq($sformatf("rand%0d", t));
    end
    for (int a = 0; a < 16; a++) begin
      loc_read(a, b);
      chk($sformatf("final_reg%0d", a), b, m[a]);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
